// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-128 core.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_state_e;

  // RCON[0] belongs to round 1
  localparam logic [9:0][7:0] RCON = {8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
                                      8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  function automatic bit unroll_legal(input int u);
    return (u == 1) || (u == 2) || (u == 5) || (u == 10);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Absolute round number 1..10; anything else yields 0
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    if (r >= 4'd1 && r <= 4'd10) return RCON[r - 4'd1];
    return 8'h00;
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round plus the matching key-schedule step.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] data,
  input  logic [127:0] rkey_in,
  input  logic [7:0]   rcon,
  input  logic         last_flag,
  output logic [127:0] data_out,
  output logic [127:0] rkey_out
);

  logic [7:0]  sub  [16];
  logic [7:0]  ksub [4];
  logic [7:0]  sh   [16];
  logic [7:0]  mx   [16];
  logic [31:0] rot_w3, temp, n0, n1, n2, n3;

  assign rot_w3 = {rkey_in[23:0], rkey_in[31:24]};

  for (genvar k = 0; k < 16; k++) begin : g_sb
    aes_sbox u_sbox (.a(data[127-8*k -: 8]), .s(sub[k]));
  end

  for (genvar j = 0; j < 4; j++) begin : g_ksb
    aes_sbox u_ksbox (.a(rot_w3[31-8*j -: 8]), .s(ksub[j]));
  end

  always_comb begin
    temp     = {ksub[0] ^ rcon, ksub[1], ksub[2], ksub[3]};
    n0       = rkey_in[127:96] ^ temp;
    n1       = rkey_in[95:64]  ^ n0;
    n2       = rkey_in[63:32]  ^ n1;
    n3       = rkey_in[31:0]   ^ n2;
    rkey_out = {n0, n1, n2, n3};

    // byte index = row + 4*column, byte 0 in the MSBs
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sh[r+4*c] = sub[r + 4*((c+r)%4)];

    for (int c = 0; c < 4; c++) begin
      mx[4*c]   = xtime(sh[4*c]) ^ xtime(sh[4*c+1]) ^ sh[4*c+1] ^ sh[4*c+2] ^ sh[4*c+3];
      mx[4*c+1] = sh[4*c] ^ xtime(sh[4*c+1]) ^ xtime(sh[4*c+2]) ^ sh[4*c+2] ^ sh[4*c+3];
      mx[4*c+2] = sh[4*c] ^ sh[4*c+1] ^ xtime(sh[4*c+2]) ^ xtime(sh[4*c+3]) ^ sh[4*c+3];
      mx[4*c+3] = xtime(sh[4*c]) ^ sh[4*c] ^ sh[4*c+1] ^ sh[4*c+2] ^ xtime(sh[4*c+3]);
    end

    data_out = '0;
    for (int k = 0; k < 16; k++)
      data_out[127-8*k -: 8] = (last_flag ? sh[k] : mx[k]) ^ rkey_out[127-8*k -: 8];
  end

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] s
);

  logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127, inv;

  // inverse computed as a^254 (maps 0 to 0 as required)
  always_comb begin
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x6   = gf_mul(x3, x3);
    x7   = gf_mul(x6, a);
    x14  = gf_mul(x7, x7);
    x15  = gf_mul(x14, a);
    x30  = gf_mul(x15, x15);
    x31  = gf_mul(x30, a);
    x62  = gf_mul(x31, x31);
    x63  = gf_mul(x62, a);
    x126 = gf_mul(x63, x63);
    x127 = gf_mul(x126, a);
    inv  = gf_mul(x127, x127);
    s    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128 encryptor, UNROLL rounds per clock, valid/ready on both sides,
// optional registered complementary output rail.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int UNROLL    = 1,
  parameter bit DUAL_RAIL = 1'b0
) (
  input  logic         AES_clk,
  input  logic         AES_rst_n,
  input  logic         AES_data_in_valid,
  output logic         AES_data_in_ready,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic         AES_data_out_valid,
  input  logic         AES_data_out_ready,
  output logic [127:0] AES_data_out,
  output logic [127:0] AES_data_out_complementary,
  output logic         AES_busy
);

  if (!unroll_legal(UNROLL)) begin : g_bad_unroll
    $error("aes_iter_core: UNROLL must be 1, 2, 5 or 10");
  end

  // rnd value seen on the clock that finishes round 10
  localparam logic [3:0] LAST_RND = 4'(11 - UNROLL);

  aes_state_e   fsm, fsm_nxt;
  logic [127:0] state_reg, rkey_reg, out_reg, comp_reg;
  logic [127:0] chain_d, chain_k;
  logic [3:0]   rnd;
  logic         load, last, in_ready_c;

  for (genvar g = 0; g < UNROLL; g++) begin : g_rnd
    logic [127:0] d_in, k_in, d_nxt, k_nxt;
    logic [3:0]   rn;
    if (g == 0) begin : g_first
      assign d_in = state_reg;
      assign k_in = rkey_reg;
    end else begin : g_next
      assign d_in = g_rnd[g-1].d_nxt;
      assign k_in = g_rnd[g-1].k_nxt;
    end
    assign rn = rnd + 4'(g);
    aes_round u_round (
      .data     (d_in),
      .rkey_in  (k_in),
      .rcon     (rcon_of(rn)),
      .last_flag(rn == 4'd10),
      .data_out (d_nxt),
      .rkey_out (k_nxt)
    );
  end

  assign chain_d = g_rnd[UNROLL-1].d_nxt;
  assign chain_k = g_rnd[UNROLL-1].k_nxt;
  assign last    = (rnd == LAST_RND);

  always_comb begin
    fsm_nxt    = fsm;
    load       = 1'b0;
    in_ready_c = 1'b0;
    case (fsm)
      IDLE: begin
        in_ready_c = 1'b1;
        if (AES_data_in_valid) begin
          load    = 1'b1;
          fsm_nxt = ROUND;
        end
      end
      ROUND: if (last) fsm_nxt = DONE;
      DONE: begin
        // hand-off edge doubles as the next accept
        in_ready_c = AES_data_out_ready;
        if (AES_data_out_ready) begin
          if (AES_data_in_valid) begin
            load    = 1'b1;
            fsm_nxt = ROUND;
          end else begin
            fsm_nxt = IDLE;
          end
        end
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      fsm       <= IDLE;
      state_reg <= '0;
      rkey_reg  <= '0;
      rnd       <= '0;
      out_reg   <= '0;
      comp_reg  <= '0;
    end else begin
      fsm <= fsm_nxt;
      if (load) begin
        state_reg <= AES_data_in ^ AES_key_in;
        rkey_reg  <= AES_key_in;
        rnd       <= 4'd1;
      end else if (fsm == ROUND) begin
        state_reg <= chain_d;
        rkey_reg  <= chain_k;
        rnd       <= rnd + 4'(UNROLL);
        if (last) begin
          out_reg  <= chain_d;
          comp_reg <= DUAL_RAIL ? ~chain_d : '0;
        end
      end
    end
  end

  // ready is held low while reset is asserted
  assign AES_data_in_ready          = in_ready_c & AES_rst_n;
  assign AES_data_out_valid         = (fsm == DONE);
  assign AES_busy                   = (fsm == ROUND);
  assign AES_data_out               = out_reg;
  assign AES_data_out_complementary = comp_reg;

endmodule

// File: tb/tb_aes_iter_core.sv
// Directed bench for aes_iter_core: FIPS-197 vectors across UNROLL, back-pressure,
// back-to-back, dual rail and mid-block reset.
module tb_aes_iter_core;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] pt, key;
  logic         vin [4];
  logic         ordy [4];
  logic         rdy_in [4];
  logic         vout [4];
  logic         busy [4];
  logic [127:0] dout [4];
  logic [127:0] dcomp [4];
  int           errors = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  // dut g: UNROLL 1,2,5,10; odd instances are dual-rail
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int UN = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
    aes_iter_core #(.UNROLL(UN), .DUAL_RAIL(g % 2 == 1)) u_dut (
      .AES_clk                   (clk),
      .AES_rst_n                 (rst_n),
      .AES_data_in_valid         (vin[g]),
      .AES_data_in_ready         (rdy_in[g]),
      .AES_data_in               (pt),
      .AES_key_in                (key),
      .AES_data_out_valid        (vout[g]),
      .AES_data_out_ready        (ordy[g]),
      .AES_data_out              (dout[g]),
      .AES_data_out_complementary(dcomp[g]),
      .AES_busy                  (busy[g])
    );
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 4; g++)
      if (rst_n === 1'b1 && vout[g] === 1'b1) begin
        if (g % 2 == 1) chk("dual_rail_xor", dout[g] ^ dcomp[g], '1);
        else            chk("comp_zero", dcomp[g], '0);
      end
  end

  // offer one block on dut idx with out_ready high; checks latency, busy span and result
  task automatic run_block(input int idx, input logic [127:0] p, input logic [127:0] k,
                           input logic [127:0] c, input int nr);
    int cyc;
    int bz;
    @(negedge clk);
    pt = p; key = k; vin[idx] = 1'b1; ordy[idx] = 1'b1;
    chk("accept_ready", rdy_in[idx], 1);
    cyc = 0; bz = 0;
    do begin
      @(negedge clk);
      vin[idx] = 1'b0;
      cyc++;
      if (busy[idx]) bz++;
    end while (!vout[idx] && cyc < 40);
    chk("latency", cyc - 1, nr);
    chk("busy_cycles", bz, nr);
    chk("ciphertext", dout[idx], c);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst_n = 1'b0; pt = '0; key = '0;
    for (int i = 0; i < 4; i++) begin vin[i] = 1'b0; ordy[i] = 1'b0; end
    repeat (2) @(negedge clk);
    chk("rst_valid", vout[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_data", dout[0], '0);
    chk("rst_ready", rdy_in[0], 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk("post_rst_ready", rdy_in[i], 1);

    run_block(0, PT_B, KEY_B, CT_B, 10);
    run_block(0, PT_C, KEY_C, CT_C, 10);
    run_block(1, PT_C, KEY_C, CT_C, 5);
    run_block(2, PT_C, KEY_C, CT_C, 2);
    run_block(3, PT_C, KEY_C, CT_C, 1);
    run_block(3, PT_B, KEY_B, CT_B, 1);

    // back-pressure on dut 0
    @(negedge clk);
    pt = PT_C; key = KEY_C; vin[0] = 1'b1; ordy[0] = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      vin[0] = 1'b0;
      cyc++;
    end while (!vout[0] && cyc < 40);
    chk("bp_valid", vout[0], 1);
    for (int i = 0; i < 20; i++) begin
      vin[0] = 1'b1; pt = PT_B; key = KEY_B;
      @(negedge clk);
      chk("bp_hold_valid", vout[0], 1);
      chk("bp_hold_data", dout[0], CT_C);
      chk("bp_in_ready", rdy_in[0], 0);
    end
    ordy[0] = 1'b1; vin[0] = 1'b0;
    @(negedge clk);
    chk("bp_one_transfer", vout[0], 0);
    chk("bp_not_consumed", busy[0], 0);
    @(negedge clk);
    chk("bp_idle_valid", vout[0], 0);

    // back-to-back on dut 0
    pt = PT_B; key = KEY_B; vin[0] = 1'b1; ordy[0] = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!vout[0] && cyc < 40);
    chk("b2b_first_valid", vout[0], 1);
    chk("b2b_first_ct", dout[0], CT_B);
    chk("b2b_handoff_ready", rdy_in[0], 1);
    pt = PT_C; key = KEY_C;
    @(negedge clk);
    vin[0] = 1'b0;
    chk("b2b_no_idle", busy[0], 1);
    chk("b2b_valid_dropped", vout[0], 0);
    cyc = 1;
    while (!vout[0] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_spacing", cyc, 11);
    chk("b2b_second_ct", dout[0], CT_C);
    @(negedge clk);
    chk("b2b_idle_after", vout[0], 0);

    // reset during round 4 of a block
    pt = PT_B; key = KEY_B; vin[0] = 1'b1; ordy[0] = 1'b1;
    @(negedge clk);
    vin[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", busy[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", vout[0], 0);
    chk("mid_rst_busy", busy[0], 0);
    chk("mid_rst_data", dout[0], '0);
    chk("mid_rst_comp", dcomp[1], '0);
    chk("mid_rst_ready", rdy_in[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_post_ready", rdy_in[0], 1);
    chk("mid_post_busy", busy[0], 0);
    run_block(0, PT_C, KEY_C, CT_C, 10);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
